// File: rtl/reaction_round_ctrl_pkg.sv
// rtl/reaction_round_ctrl_pkg.sv - state/fault encodings and width helpers for the reaction round controller
package reaction_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_PROMPT  = 3'd2,
        ST_RESULT  = 3'd3,
        ST_FAULT   = 3'd4,
        ST_SUMMARY = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE        = 2'd0,
        FAULT_FALSE_START = 2'd1,
        FAULT_WRONG_SW    = 2'd2,
        FAULT_TIMEOUT     = 2'd3
    } fault_t;

    function automatic int sel_width(input int num_sw);
        return $clog2(num_sw);
    endfunction

    // The counter must hold the full delay sum in WAIT and the reaction time in PROMPT.
    function automatic int cnt_width(input int rand_w, input int time_w);
        return (rand_w + 1 > time_w) ? rand_w + 1 : time_w;
    endfunction

endpackage

// File: rtl/reaction_round_ctrl_if.sv
// rtl/reaction_round_ctrl_if.sv - player/display signal bundle of the reaction round controller
interface reaction_round_ctrl_if #(
    parameter int NUM_SW = 10,
    parameter int RAND_W = 15,
    parameter int TIME_W = 20
);
    logic              start;
    logic [NUM_SW-1:0] switch;
    logic [RAND_W-1:0] rand_num;
    logic              tick;
    logic [NUM_SW-1:0] led;
    logic [2:0]        state_o;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] best_q;
    logic [1:0]        fault;
    logic [3:0]        round_idx;
    logic              done;

    modport master (
        output start, switch, rand_num, tick,
        input  led, state_o, time_q, best_q, fault, round_idx, done
    );

    modport slave (
        input  start, switch, rand_num, tick,
        output led, state_o, time_q, best_q, fault, round_idx, done
    );
endinterface

// File: rtl/reaction_round_ctrl_tick_counter.sv
// rtl/reaction_round_ctrl_tick_counter.sv - tick counter with synchronous clear and saturation limit
module tick_counter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (en && (value < limit)) begin
            value <= value + W'(1);
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// rtl/reaction_round_ctrl.sv - multi-round reaction-time game controller
module reaction_round_ctrl
    import reaction_round_ctrl_pkg::*;
#(
    parameter int NUM_SW   = 10,
    parameter int RAND_W   = 15,
    parameter int TIME_W   = 20,
    parameter int MIN_WAIT = 500,
    parameter int TIMEOUT  = 5000,
    parameter int ROUNDS   = 5
) (
    input logic                 clk,
    input logic                 rst,
    reaction_round_ctrl_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_SW);
    localparam int CNT_W = cnt_width(RAND_W, TIME_W);
    localparam int DLY_W = RAND_W + 1;

    state_t            state;
    fault_t            fault;
    logic [NUM_SW-1:0] led;
    logic [NUM_SW-1:0] target_q;
    logic [DLY_W-1:0]  delay_q;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] best_q;
    logic [3:0]        round_idx;
    logic              done;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_lim;
    logic [TIME_W-1:0] cnt_t;
    logic              cnt_clr;
    logic              cnt_en;
    logic              in_timing;
    logic              delay_hit;
    logic              go;
    logic              last_round;
    logic [SEL_W:0]    s_ext;
    logic [SEL_W-1:0]  sel_new;
    logic [NUM_SW-1:0] target_new;
    logic [DLY_W-1:0]  delay_new;

    // Folding the raw select back into range needs only one subtraction since s < 2*NUM_SW.
    assign s_ext      = {1'b0, bus.rand_num[SEL_W-1:0]};
    assign sel_new    = (s_ext >= (SEL_W+1)'(NUM_SW)) ? SEL_W'(s_ext - (SEL_W+1)'(NUM_SW))
                                                      : s_ext[SEL_W-1:0];
    assign target_new = NUM_SW'(1) << sel_new;
    assign delay_new  = DLY_W'(MIN_WAIT) + {1'b0, bus.rand_num};

    assign go         = bus.start && (bus.switch == '0);
    assign last_round = (round_idx == 4'(ROUNDS - 1));
    assign in_timing  = (state == ST_WAIT) || (state == ST_PROMPT);
    assign delay_hit  = (state == ST_WAIT) && (cnt == CNT_W'(delay_q));
    assign cnt_clr    = rst || !in_timing || delay_hit;
    assign cnt_en     = bus.tick && in_timing;
    assign cnt_lim    = (state == ST_PROMPT) ? CNT_W'(TIMEOUT) : CNT_W'(delay_q);
    assign cnt_t      = TIME_W'(cnt);

    tick_counter #(.W(CNT_W)) u_tick_counter (
        .clk   (clk),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (cnt_lim),
        .value (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fault     <= FAULT_NONE;
            led       <= '0;
            target_q  <= '0;
            delay_q   <= '0;
            time_q    <= '0;
            best_q    <= '1;
            round_idx <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_SUMMARY: begin
                    if (go) begin
                        state     <= ST_WAIT;
                        round_idx <= '0;
                        best_q    <= '1;
                        fault     <= FAULT_NONE;
                        done      <= 1'b0;
                        delay_q   <= delay_new;
                        target_q  <= target_new;
                    end
                end
                ST_WAIT: begin
                    if (bus.switch != '0) begin
                        state <= ST_FAULT;
                        fault <= FAULT_FALSE_START;
                    end else if (delay_hit) begin
                        state <= ST_PROMPT;
                        led   <= target_q;
                    end
                end
                ST_PROMPT: begin
                    // A correct press beats a timeout landing in the same cycle.
                    if (bus.switch == led) begin
                        state  <= ST_RESULT;
                        time_q <= cnt_t;
                        led    <= '0;
                        if (cnt_t < best_q) begin
                            best_q <= cnt_t;
                        end
                    end else if (bus.switch != '0) begin
                        state <= ST_FAULT;
                        fault <= FAULT_WRONG_SW;
                        led   <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        state  <= ST_FAULT;
                        fault  <= FAULT_TIMEOUT;
                        time_q <= TIME_W'(TIMEOUT);
                        led    <= '0;
                    end
                end
                ST_RESULT: begin
                    if (last_round) begin
                        state <= ST_SUMMARY;
                        done  <= 1'b1;
                    end else if (go) begin
                        state     <= ST_WAIT;
                        round_idx <= round_idx + 4'd1;
                        delay_q   <= delay_new;
                        target_q  <= target_new;
                    end
                end
                ST_FAULT: begin
                    if (go) begin
                        fault <= FAULT_NONE;
                        if (last_round) begin
                            state <= ST_SUMMARY;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_WAIT;
                            round_idx <= round_idx + 4'd1;
                            delay_q   <= delay_new;
                            target_q  <= target_new;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.led       = led;
    assign bus.state_o   = state;
    assign bus.time_q    = time_q;
    assign bus.best_q    = best_q;
    assign bus.fault     = fault;
    assign bus.round_idx = round_idx;
    assign bus.done      = done;

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// tb/tb_reaction_round_ctrl.sv - directed self-checking bench for reaction_round_ctrl
module tb_reaction_round_ctrl;

    localparam logic [2:0]  S_IDLE = 3'd0, S_WAIT = 3'd1, S_PROMPT = 3'd2,
                            S_RESULT = 3'd3, S_FAULT = 3'd4, S_SUMMARY = 3'd5;
    localparam logic [19:0] ALL_ONES = 20'hFFFFF;

    logic clk;
    logic rst;
    int   tests;
    int   failed;

    reaction_round_ctrl_if #(.NUM_SW(10), .RAND_W(15), .TIME_W(20)) bus ();

    reaction_round_ctrl #(
        .NUM_SW(10), .RAND_W(15), .TIME_W(20),
        .MIN_WAIT(4), .TIMEOUT(20), .ROUNDS(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            step();
        end
        bus.tick = 1'b0;
    endtask

    task automatic go(input logic [14:0] rn);
        bus.rand_num = rn;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic press(input logic [9:0] sw);
        bus.switch = sw;
        step();
        bus.switch = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.rand_num = 15'h7FFF;
        bus.tick     = 1'b1;
        do_reset();
        bus.tick     = 1'b0;
        tests++; if (bus.state_o !== S_IDLE) begin failed++; $display("FAIL reset_state got=%0d exp=%0d", bus.state_o, S_IDLE); end
        tests++; if (bus.led !== 10'd0) begin failed++; $display("FAIL reset_led got=%h exp=0", bus.led); end
        tests++; if (bus.time_q !== 20'd0) begin failed++; $display("FAIL reset_time got=%0d exp=0", bus.time_q); end
        tests++; if (bus.best_q !== ALL_ONES) begin failed++; $display("FAIL reset_best got=%h exp=%h", bus.best_q, ALL_ONES); end
        tests++; if (bus.fault !== 2'd0 || bus.round_idx !== 4'd0 || bus.done !== 1'b0) begin
            failed++; $display("FAIL reset_misc fault=%0d round=%0d done=%0d exp=0/0/0", bus.fault, bus.round_idx, bus.done);
        end
    endtask

    task automatic test_basic_round();
        go(15'd12);
        tests++; if (bus.state_o !== S_WAIT) begin failed++; $display("FAIL basic_wait got=%0d exp=%0d", bus.state_o, S_WAIT); end
        ticks(16);
        tests++; if (bus.state_o !== S_WAIT || bus.led !== 10'd0) begin
            failed++; $display("FAIL basic_pre_prompt state=%0d led=%h exp=%0d/0", bus.state_o, bus.led, S_WAIT);
        end
        step();
        tests++; if (bus.state_o !== S_PROMPT || bus.led !== 10'b100) begin
            failed++; $display("FAIL basic_prompt state=%0d led=%h exp=%0d/004", bus.state_o, bus.led, S_PROMPT);
        end
        ticks(7);
        press(10'b100);
        tests++; if (bus.state_o !== S_RESULT) begin failed++; $display("FAIL basic_result got=%0d exp=%0d", bus.state_o, S_RESULT); end
        tests++; if (bus.time_q !== 20'd7) begin failed++; $display("FAIL basic_time got=%0d exp=7", bus.time_q); end
        tests++; if (bus.best_q !== 20'd7 || bus.led !== 10'd0) begin
            failed++; $display("FAIL basic_best best=%0d led=%h exp=7/0", bus.best_q, bus.led);
        end
    endtask

    task automatic test_wrong_switch();
        go(15'd13);
        tests++; if (bus.round_idx !== 4'd1) begin failed++; $display("FAIL wrong_round got=%0d exp=1", bus.round_idx); end
        ticks(17);
        step();
        tests++; if (bus.state_o !== S_PROMPT || bus.led !== 10'b1000) begin
            failed++; $display("FAIL wrong_prompt state=%0d led=%h exp=%0d/008", bus.state_o, bus.led, S_PROMPT);
        end
        press(10'b10_0000);
        tests++; if (bus.state_o !== S_FAULT || bus.fault !== 2'd2) begin
            failed++; $display("FAIL wrong_fault state=%0d fault=%0d exp=%0d/2", bus.state_o, bus.fault, S_FAULT);
        end
        tests++; if (bus.led !== 10'd0 || bus.time_q !== 20'd7) begin
            failed++; $display("FAIL wrong_outputs led=%h time=%0d exp=0/7", bus.led, bus.time_q);
        end
    endtask

    task automatic test_false_start();
        go(15'd0);
        tests++; if (bus.state_o !== S_WAIT || bus.fault !== 2'd0 || bus.round_idx !== 4'd2) begin
            failed++; $display("FAIL false_arm state=%0d fault=%0d round=%0d exp=%0d/0/2", bus.state_o, bus.fault, bus.round_idx, S_WAIT);
        end
        ticks(4);
        press(10'b1);
        tests++; if (bus.state_o !== S_FAULT || bus.fault !== 2'd1) begin
            failed++; $display("FAIL false_fault state=%0d fault=%0d exp=%0d/1", bus.state_o, bus.fault, S_FAULT);
        end
        tests++; if (bus.led !== 10'd0 || bus.best_q !== 20'd7) begin
            failed++; $display("FAIL false_outputs led=%h best=%0d exp=0/7", bus.led, bus.best_q);
        end
        go(15'd0);
        tests++; if (bus.state_o !== S_SUMMARY || bus.done !== 1'b1 || bus.fault !== 2'd0) begin
            failed++; $display("FAIL false_summary state=%0d done=%0d fault=%0d exp=%0d/1/0", bus.state_o, bus.done, bus.fault, S_SUMMARY);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        go(15'd0);
        ticks(4);
        step();
        tests++; if (bus.state_o !== S_PROMPT || bus.led !== 10'b1) begin
            failed++; $display("FAIL tmo_prompt state=%0d led=%h exp=%0d/001", bus.state_o, bus.led, S_PROMPT);
        end
        ticks(20);
        tests++; if (bus.state_o !== S_PROMPT) begin failed++; $display("FAIL tmo_early got=%0d exp=%0d", bus.state_o, S_PROMPT); end
        step();
        tests++; if (bus.state_o !== S_FAULT || bus.fault !== 2'd3 || bus.time_q !== 20'd20) begin
            failed++; $display("FAIL tmo_fault state=%0d fault=%0d time=%0d exp=%0d/3/20", bus.state_o, bus.fault, bus.time_q, S_FAULT);
        end
        go(15'd0);
        ticks(4);
        step();
        ticks(19);
        bus.tick = 1'b1;
        press(10'b1);
        bus.tick = 1'b0;
        tests++; if (bus.state_o !== S_RESULT || bus.time_q !== 20'd19 || bus.best_q !== 20'd19) begin
            failed++; $display("FAIL tmo_race state=%0d time=%0d best=%0d exp=%0d/19/19", bus.state_o, bus.time_q, bus.best_q, S_RESULT);
        end
    endtask

    task automatic test_session();
        int times [3] = '{9, 5, 7};
        do_reset();
        for (int r = 0; r < 3; r++) begin
            go(15'd0);
            ticks(4);
            step();
            ticks(times[r]);
            press(10'b1);
            tests++; if (bus.time_q !== 20'(times[r]) || bus.round_idx !== 4'(r)) begin
                failed++; $display("FAIL session_round%0d time=%0d round=%0d exp=%0d/%0d", r, bus.time_q, bus.round_idx, times[r], r);
            end
        end
        tests++; if (bus.state_o !== S_RESULT || bus.best_q !== 20'd5) begin
            failed++; $display("FAIL session_last state=%0d best=%0d exp=%0d/5", bus.state_o, bus.best_q, S_RESULT);
        end
        step();
        tests++; if (bus.state_o !== S_SUMMARY || bus.done !== 1'b1 || bus.best_q !== 20'd5) begin
            failed++; $display("FAIL session_summary state=%0d done=%0d best=%0d exp=%0d/1/5", bus.state_o, bus.done, bus.best_q, S_SUMMARY);
        end
        bus.start = 1'b1;
        press(10'b10);
        bus.start = 1'b0;
        tests++; if (bus.state_o !== S_SUMMARY) begin failed++; $display("FAIL session_ignore got=%0d exp=%0d", bus.state_o, S_SUMMARY); end
        go(15'd0);
        tests++; if (bus.state_o !== S_WAIT || bus.round_idx !== 4'd0 || bus.best_q !== ALL_ONES || bus.done !== 1'b0) begin
            failed++; $display("FAIL session_restart state=%0d round=%0d best=%h done=%0d exp=%0d/0/%h/0",
                               bus.state_o, bus.round_idx, bus.best_q, bus.done, S_WAIT, ALL_ONES);
        end
    endtask

    task automatic test_reset_mid();
        ticks(4);
        step();
        ticks(3);
        press(10'b1);
        go(15'd0);
        ticks(4);
        step();
        tests++; if (bus.state_o !== S_PROMPT || bus.round_idx !== 4'd1 || bus.time_q !== 20'd3) begin
            failed++; $display("FAIL mid_setup state=%0d round=%0d time=%0d exp=%0d/1/3", bus.state_o, bus.round_idx, bus.time_q, S_PROMPT);
        end
        ticks(2);
        do_reset();
        tests++; if (bus.state_o !== S_IDLE || bus.led !== 10'd0 || bus.fault !== 2'd0) begin
            failed++; $display("FAIL mid_state state=%0d led=%h fault=%0d exp=%0d/0/0", bus.state_o, bus.led, bus.fault, S_IDLE);
        end
        tests++; if (bus.time_q !== 20'd0 || bus.round_idx !== 4'd0 || bus.best_q !== ALL_ONES) begin
            failed++; $display("FAIL mid_regs time=%0d round=%0d best=%h exp=0/0/%h", bus.time_q, bus.round_idx, bus.best_q, ALL_ONES);
        end
        bus.start = 1'b1;
        press(10'b1);
        bus.start = 1'b0;
        tests++; if (bus.state_o !== S_IDLE) begin failed++; $display("FAIL idle_ignore got=%0d exp=%0d", bus.state_o, S_IDLE); end
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.switch   = '0;
        bus.rand_num = '0;
        bus.tick     = 1'b0;
        test_reset();
        test_basic_round();
        test_wrong_switch();
        test_false_start();
        test_timeout();
        test_session();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
